partial_sum_serializer: RTL and testbench



---
 rtl/partial_sum_serializer.sv | 110 +++++++++++
 tb/tb_partial_sum_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/partial_sum_serializer.sv
// Gathers one word per lane, then replays them in lane order tagged with the lane index.
// Output valid 1 cycle after the last lane lands; lanes are held off (tready=0) until the group drains.
module partial_sum_serializer #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [LANES-1:0]              s_axis_tvalid,
  output logic [LANES-1:0]              s_axis_tready,
  input  logic [LANES-1:0]              s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          err_unaligned
);

  typedef enum logic {COLLECT, EMIT} state_t;

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(LANES - 1);

  state_t                state, state_nxt;
  logic [LANES-1:0]      cap_valid, cap_last;
  logic [LANES-1:0]      hs, cap_valid_nxt, cap_last_nxt;
  logic [DATA_WIDTH-1:0] cap_data [LANES];
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ID_WIDTH-1:0]   idx;
  logic                  last_beat;
  logic                  group_done;
  logic                  beat_done;

  // Ready is forced low while reset is held so nothing is offered mid-reset.
  assign s_axis_tready = (state == COLLECT && rst) ? ~cap_valid : '0;
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign cap_valid_nxt = cap_valid | hs;
  assign cap_last_nxt  = (cap_last & ~hs) | (s_axis_tlast & hs);
  assign last_beat     = (idx == LAST_IDX);

  generate
    if (LANES == 1) begin : g_one
      assign sel_data = cap_data[0];
    end else begin : g_many
      assign sel_data = cap_data[idx];
    end
  endgenerate

  assign m_axis_tvalid = (state == EMIT);
  assign m_axis_tdata  = m_axis_tvalid ? sel_data : '0;
  assign m_axis_tid    = idx;
  // Lane 0 decides end-of-run when lanes disagree.
  assign m_axis_tlast  = m_axis_tvalid && last_beat && cap_last[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    group_done = 1'b0;
    beat_done  = 1'b0;
    case (state)
      COLLECT: begin
        if (&cap_valid_nxt) begin
          state_nxt  = EMIT;
          group_done = 1'b1;
        end
      end
      EMIT: begin
        if (m_axis_tready) begin
          beat_done = 1'b1;
          if (last_beat) state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_valid     <= '0;
      cap_last      <= '0;
      idx           <= '0;
      err_unaligned <= 1'b0;
      for (int i = 0; i < LANES; i++) cap_data[i] <= '0;
    end else begin
      err_unaligned <= group_done && !((&cap_last_nxt) || !(|cap_last_nxt));
      if (state == COLLECT) begin
        cap_valid <= cap_valid_nxt;
        cap_last  <= cap_last_nxt;
        idx       <= '0;
        for (int i = 0; i < LANES; i++) begin
          if (hs[i]) cap_data[i] <= s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (beat_done) begin
        if (last_beat) begin
          cap_valid <= '0;
          idx       <= '0;
        end else begin
          idx <= idx + ID_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_partial_sum_serializer.sv
// Bench for partial_sum_serializer: 4-lane and 1-lane instances against a queue-based model.
module tb_partial_sum_serializer;
  localparam int L  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [L*DW-1:0] s4_dat;
  logic [L-1:0]    s4_vld, s4_rdy, s4_last;
  logic [DW-1:0]   m4_dat;
  logic            m4_vld, m4_rdy, m4_last, err4;
  logic [1:0]      m4_id;

  logic [DW-1:0]   s1_dat;
  logic [0:0]      s1_vld, s1_rdy, s1_last;
  logic [DW-1:0]   m1_dat;
  logic            m1_vld, m1_rdy, m1_last, err1;
  logic [0:0]      m1_id;

  partial_sum_serializer #(.LANES(4), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s4_dat), .s_axis_tvalid(s4_vld), .s_axis_tready(s4_rdy), .s_axis_tlast(s4_last),
    .m_axis_tdata(m4_dat), .m_axis_tvalid(m4_vld), .m_axis_tready(m4_rdy), .m_axis_tlast(m4_last),
    .m_axis_tid(m4_id), .err_unaligned(err4)
  );

  partial_sum_serializer #(.LANES(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_dat), .s_axis_tvalid(s1_vld), .s_axis_tready(s1_rdy), .s_axis_tlast(s1_last),
    .m_axis_tdata(m1_dat), .m_axis_tvalid(m1_vld), .m_axis_tready(m1_rdy), .m_axis_tlast(m1_last),
    .m_axis_tid(m1_id), .err_unaligned(err1)
  );

  typedef struct packed { logic [DW-1:0] d; logic l; } word_t;
  typedef struct packed { logic [DW-1:0] d; logic [1:0] id; logic l; } beat_t;

  word_t         lane_q [L][$];
  word_t         src1_q [$];
  beat_t         q4 [$];
  beat_t         q1 [$];
  int            dly4 [L];
  int            dly1;
  logic [L-1:0]  acc4, got4, got_l;
  logic [DW-1:0] got_d [L];
  logic          acc1, err_pend4;
  int            rdy_mode, rdy_phase;
  bit            rand_dly;
  int            errors = 0;
  int            checks = 0;
  int            pops4 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_group(input logic [L*DW-1:0] d, input logic [L-1:0] l);
    word_t w;
    for (int i = 0; i < L; i++) begin
      w.d = d[i*DW +: DW];
      w.l = l[i];
      lane_q[i].push_back(w);
    end
  endtask

  // Called right after a falling edge: retire accepted words, present new ones, set output ready.
  task automatic drive();
    word_t w;
    for (int i = 0; i < L; i++) begin
      if (acc4[i]) begin
        s4_vld[i] = 1'b0;
        dly4[i]   = rand_dly ? int'($urandom_range(0, 3)) : 0;
      end
      if (!s4_vld[i] && lane_q[i].size() > 0) begin
        if (dly4[i] == 0) begin
          w = lane_q[i].pop_front();
          s4_dat[i*DW +: DW] = w.d;
          s4_last[i]         = w.l;
          s4_vld[i]          = 1'b1;
        end else begin
          dly4[i]--;
        end
      end
    end
    acc4 = '0;
    if (acc1) begin
      s1_vld = 1'b0;
      dly1   = rand_dly ? int'($urandom_range(0, 3)) : 0;
    end
    if (!s1_vld[0] && src1_q.size() > 0) begin
      if (dly1 == 0) begin
        w = src1_q.pop_front();
        s1_dat  = w.d;
        s1_last = w.l;
        s1_vld  = 1'b1;
      end else begin
        dly1--;
      end
    end
    acc1 = 1'b0;
    case (rdy_mode)
      0:       m4_rdy = 1'b1;
      1:       m4_rdy = (rdy_phase % 3 == 0);
      default: m4_rdy = 1'($urandom_range(0, 1));
    endcase
    rdy_phase++;
    m1_rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Checks outputs against the model for this cycle, then advances the model past the next rising edge.
  task automatic tick();
    logic [L-1:0] er;
    logic         er1;
    beat_t        b;
    #1;
    er = (q4.size() == 0) ? ~got4 : '0;
    check("s4_tready", s4_rdy, er);
    check("m4_tvalid", m4_vld, q4.size() != 0);
    check("m4_err", err4, err_pend4);
    err_pend4 = 1'b0;
    if (q4.size() != 0) begin
      b = q4[0];
      check("m4_tdata", m4_dat, b.d);
      check("m4_tid", m4_id, b.id);
      check("m4_tlast", m4_last, b.l);
      if (m4_rdy) begin
        void'(q4.pop_front());
        pops4++;
      end
    end
    acc4 = s4_vld & er;
    for (int i = 0; i < L; i++) begin
      if (acc4[i]) begin
        got_d[i] = s4_dat[i*DW +: DW];
        got_l[i] = s4_last[i];
      end
    end
    got4 = got4 | acc4;
    if (&got4) begin
      for (int i = 0; i < L; i++) begin
        b.d  = got_d[i];
        b.id = 2'(i);
        b.l  = (i == L - 1) && got_l[0];
        q4.push_back(b);
      end
      err_pend4 = !(got_l == '0 || got_l == '1);
      got4 = '0;
    end

    er1 = (q1.size() == 0);
    check("s1_tready", s1_rdy, er1);
    check("m1_tvalid", m1_vld, q1.size() != 0);
    check("m1_err", err1, 0);
    if (q1.size() != 0) begin
      b = q1[0];
      check("m1_tdata", m1_dat, b.d);
      check("m1_tid", m1_id, 0);
      check("m1_tlast", m1_last, b.l);
      if (m1_rdy) void'(q1.pop_front());
    end
    acc1 = s1_vld[0] && er1;
    if (acc1) begin
      b.d = s1_dat; b.id = 2'd0; b.l = s1_last[0];
      q1.push_back(b);
    end
    @(negedge clk);
  endtask

  function automatic bit busy();
    bit r;
    r = (q4.size() != 0) || (got4 != '0) || (s4_vld != '0) || (acc4 != '0) ||
        (q1.size() != 0) || (src1_q.size() != 0) || s1_vld[0] || acc1;
    for (int i = 0; i < L; i++) if (lane_q[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (busy() && n < 2000) begin
      drive();
      tick();
      n++;
    end
    if (n >= 2000) check("drain_timeout", 32'(n), 0);
    repeat (2) begin
      drive();
      tick();
    end
  endtask

  initial begin
    int   n, start;
    logic [L*DW-1:0] d;
    logic [L-1:0]    l;
    word_t w;

    rst = 1'b0;
    s4_dat = '0; s4_vld = '0; s4_last = '0; m4_rdy = 1'b0;
    s1_dat = '0; s1_vld = '0; s1_last = '0; m1_rdy = 1'b0;
    acc4 = '0; got4 = '0; got_l = '0; acc1 = 1'b0; err_pend4 = 1'b0;
    dly1 = 0; rdy_mode = 0; rdy_phase = 0; rand_dly = 1'b0;
    for (int i = 0; i < L; i++) begin dly4[i] = 0; got_d[i] = '0; end

    repeat (2) @(negedge clk);
    check("rst_m4_tvalid", m4_vld, 0);
    check("rst_s4_tready", s4_rdy, 0);
    check("rst_m4_tdata", m4_dat, 0);
    check("rst_m4_tid", m4_id, 0);
    check("rst_m4_tlast", m4_last, 0);
    check("rst_err4", err4, 0);
    check("rst_s1_tready", s1_rdy, 0);
    check("rst_m1_tvalid", m1_vld, 0);
    rst = 1'b1;

    // All lanes together, tlast low, sink always ready.
    load_group({16'h0044, 16'h0033, 16'h0022, 16'h0011}, 4'b0000);
    drain();

    // Staggered arrival 3,1,0,2.
    dly4 = '{2, 1, 3, 0};
    load_group({16'h0d02, 16'h0c02, 16'h0b02, 16'h0a02}, 4'b0000);
    drain();

    // Stalling sink with a second group waiting at the inputs.
    rdy_mode = 1;
    load_group({16'h1004, 16'h1003, 16'h1002, 16'h1001}, 4'b0000);
    load_group({16'h2004, 16'h2003, 16'h2002, 16'h2001}, 4'b0000);
    drain();
    rdy_mode = 0;

    // Aligned end-of-run, then a misaligned group with lane 0 high.
    load_group({16'h3004, 16'h3003, 16'h3002, 16'h3001}, 4'b1111);
    load_group({16'h4004, 16'h4003, 16'h4002, 16'h4001}, 4'b0101);
    load_group({16'h5004, 16'h5003, 16'h5002, 16'h5001}, 4'b1010);
    drain();

    // Reset in the middle of emitting.
    load_group({16'h6004, 16'h6003, 16'h6002, 16'h6001}, 4'b0000);
    start = pops4;
    n = 0;
    while (pops4 - start < 2 && n < 100) begin
      drive();
      tick();
      n++;
    end
    check("t5_two_beats", 32'(pops4 - start), 2);
    #2 rst = 1'b0;
    #1;
    check("t5_async_tvalid", m4_vld, 0);
    check("t5_tready_in_rst", s4_rdy, 0);
    q4.delete(); got4 = '0; acc4 = '0; err_pend4 = 1'b0; s4_vld = '0;
    q1.delete(); src1_q.delete(); s1_vld = '0; acc1 = 1'b0;
    for (int i = 0; i < L; i++) begin lane_q[i].delete(); dly4[i] = 0; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    load_group({16'h7004, 16'h7003, 16'h7002, 16'h7001}, 4'b0000);
    drain();

    // Random groups with random gaps and backpressure.
    rand_dly = 1'b1;
    rdy_mode = 2;
    for (int g = 0; g < 20; g++) begin
      for (int i = 0; i < L; i++) d[i*DW +: DW] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) l = 4'($urandom);
      else                           l = (g == 19) ? 4'b1111 : 4'b0000;
      load_group(d, l);
    end
    drain();

    // Single-lane instance.
    for (int k = 0; k < 10; k++) begin
      w.d = 16'($urandom);
      w.l = 1'($urandom_range(0, 1));
      src1_q.push_back(w);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
